// File: rtl/imem_loader.sv
// Byte-stream loader for the CPU instruction memory: header word count, little-endian
// data words written one per strobe, XOR checksum gating release of the CPU reset.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
    localparam logic [ADDR_W:0] WL_ONE  = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W:0]   n_words;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [7:0]        csum;
    logic              accept;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == ST_HEADER) || (state == ST_DATA) || (state == ST_CHECK);
    assign cpu_reset = (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            byte_idx     <= '0;
            csum         <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state        <= ST_HEADER;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        csum         <= '0;
                    end
                end
                ST_HEADER: begin
                    if (accept) begin
                        // Only the low bits are kept; the range check below guarantees they suffice.
                        n_words  <= in_data[ADDR_W:0];
                        byte_idx <= '0;
                        if (in_data == 8'd0 || in_data > DEPTH_B)
                            state <= ST_ERROR;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                // Last byte of the word goes straight into the write data,
                                // so the strobe overlaps acceptance of the next byte.
                                imem_we      <= 1'b1;
                                imem_addr    <= words_loaded[ADDR_W-1:0];
                                imem_wdata   <= {in_data, word_buf};
                                words_loaded <= words_loaded + WL_ONE;
                                if (words_loaded + WL_ONE == n_words)
                                    state <= ST_CHECK;
                            end
                        endcase
                    end
                end
                ST_CHECK: begin
                    if (accept)
                        state <= (in_data == csum) ? ST_DONE : ST_ERROR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad checksum/header, gaps, mid-load reset, start while busy.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [5:0]  words_loaded;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int wr_count = 0;
    int dup_cnt = 0;
    int pulse_cyc [64];
    logic [31:0] shadow [32];
    logic        prev_we = 1'b0;
    logic [4:0]  prev_addr = '0;
    int base;

    logic [7:0] img [12] = '{8'hb3, 8'h03, 8'h53, 8'h00,
                             8'h33, 8'h85, 8'h84, 8'h40,
                             8'h93, 8'h06, 8'h16, 8'h00};

    imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Plays the role of the instruction memory and records strobe timing.
    always @(negedge clk) begin
        if (imem_we) begin
            shadow[imem_addr]       <= imem_wdata;
            pulse_cyc[wr_count % 64] <= cyc;
            wr_count                <= wr_count + 1;
            if (prev_we && imem_addr == prev_addr) dup_cnt <= dup_cnt + 1;
        end
        prev_we   <= imem_we;
        prev_addr <= imem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] cs, input bit gaps);
        send_byte(8'h03, 0);
        for (int i = 0; i < 12; i++)
            send_byte(img[i], gaps ? int'($urandom_range(1, 3)) : 0);
        send_byte(cs, gaps ? int'($urandom_range(1, 3)) : 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;

        // Nominal back-to-back load
        pulse_start();
        chk("hdr_ready", 32'(in_ready), 32'd1);
        base = wr_count;
        send_image(8'h12, 1'b0);
        chk("nom_done", 32'(done), 32'd1);
        chk("nom_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("nom_error", 32'(error), 32'd0);
        chk("nom_ready", 32'(in_ready), 32'd0);
        chk("nom_words", 32'(words_loaded), 32'd3);
        chk("nom_wr_count", 32'(wr_count - base), 32'd3);
        chk("nom_mem0", shadow[0], 32'h005303b3);
        chk("nom_mem1", shadow[1], 32'h40848533);
        chk("nom_mem2", shadow[2], 32'h00160693);
        chk("nom_gap01", 32'(pulse_cyc[base + 1] - pulse_cyc[base]), 32'd4);
        chk("nom_gap12", 32'(pulse_cyc[base + 2] - pulse_cyc[base + 1]), 32'd4);
        chk("nom_hold_addr", 32'(imem_addr), 32'd2);
        chk("nom_hold_wdata", imem_wdata, 32'h00160693);

        // Bad checksum
        pulse_start();
        base = wr_count;
        send_image(8'h13, 1'b0);
        chk("bcs_error", 32'(error), 32'd1);
        chk("bcs_done", 32'(done), 32'd0);
        chk("bcs_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("bcs_ready", 32'(in_ready), 32'd0);
        chk("bcs_wr_count", 32'(wr_count - base), 32'd3);

        // Bad headers, then a good load
        base = wr_count;
        pulse_start();
        send_byte(8'h00, 0);
        chk("hdr0_error", 32'(error), 32'd1);
        chk("hdr0_ready", 32'(in_ready), 32'd0);
        pulse_start();
        chk("hdr_restart_error", 32'(error), 32'd0);
        send_byte(8'h21, 0);
        chk("hdr33_error", 32'(error), 32'd1);
        chk("hdr_no_we", 32'(wr_count - base), 32'd0);
        pulse_start();
        send_image(8'h12, 1'b0);
        chk("hdr_recover_done", 32'(done), 32'd1);

        // Gaps in in_valid
        pulse_start();
        base = wr_count;
        send_image(8'h12, 1'b1);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_wr_count", 32'(wr_count - base), 32'd3);
        chk("gap_mem1", shadow[1], 32'h40848533);
        chk("gap_mem2", shadow[2], 32'h00160693);
        chk("gap_words", 32'(words_loaded), 32'd3);
        chk("dup_strobe", 32'(dup_cnt), 32'd0);

        // Reset after 6 data bytes
        pulse_start();
        base = wr_count;
        send_byte(8'h03, 0);
        for (int i = 0; i < 6; i++) send_byte(img[i], 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mr_ready", 32'(in_ready), 32'd0);
        chk("mr_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mr_words", 32'(words_loaded), 32'd0);
        chk("mr_we", 32'(imem_we), 32'd0);
        chk("mr_wr_count", 32'(wr_count - base), 32'd1);
        chk("mr_mem0", shadow[0], 32'h005303b3);

        // Single-word reload
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'hef, 0);
        send_byte(8'hbe, 0);
        send_byte(8'had, 0);
        send_byte(8'hde, 0);
        send_byte(8'h22, 0);
        chk("one_done", 32'(done), 32'd1);
        chk("one_mem0", shadow[0], 32'hdeadbeef);
        chk("one_words", 32'(words_loaded), 32'd1);

        // Start ignored while busy
        pulse_start();
        send_byte(8'h03, 0);
        for (int i = 0; i < 4; i++) send_byte(img[i], 0);
        chk("first_we", 32'(imem_we), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'd0);
        chk("first_wdata", imem_wdata, 32'h005303b3);
        chk("first_words", 32'(words_loaded), 32'd1);
        send_byte(img[4], 0);
        pulse_start();
        chk("ign_data_ready", 32'(in_ready), 32'd1);
        chk("ign_data_words", 32'(words_loaded), 32'd1);
        for (int i = 5; i < 12; i++) send_byte(img[i], 0);
        pulse_start();
        chk("ign_check_ready", 32'(in_ready), 32'd1);
        chk("ign_check_words", 32'(words_loaded), 32'd3);
        send_byte(8'h12, 0);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_mem0", shadow[0], 32'h005303b3);

        // Start from DONE
        pulse_start();
        chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_ready", 32'(in_ready), 32'd1);
        chk("restart_words", 32'(words_loaded), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Streams a program image into the CPU's 32-entry instruction memory through a byte-wide valid/ready input, one byte per handshake.
- Writes the instruction memory at the word index that the CPU later reads as pc>>2.
- Holds the CPU in reset while loading and releases it only after the image checksum verifies.
- Sits between a host/debug byte source and the instruction_memory write port, which it drives.

Parameters:
- DEPTH, 32, number of 32-bit instruction words in instruction memory.
- ADDR_W, 5, word-index width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte. A transfer occurs when in_valid && in_ready at posedge.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word index for the write.
- imem_wdata  out  32  instruction word for the write.
- cpu_reset  out  1  reset to the CPU core. High in every state except DONE.
- done  out  1  image loaded and verified.
- error  out  1  bad header or checksum.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (synchronous, any state, including mid-load):
  - state=IDLE.
  - imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0.
  - cpu_reset=1, done=0, error=0, in_ready=0.
  - Already-written memory words are not touched.
- States: IDLE, HEADER, DATA, CHECK, DONE, ERROR.
- in_ready=1 exactly in HEADER, DATA and CHECK. It is decoded from the registered state and has no dependence on in_valid.
- Start handling:
  - IDLE/DONE/ERROR + start -> HEADER.
  - Entering HEADER clears: words_loaded, the byte counter, the 8-bit checksum accumulator, done and error.
  - start in HEADER, DATA or CHECK is ignored.
- HEADER:
  - The accepted byte is N, the word count.
  - N==0 or N>DEPTH -> ERROR.
  - Otherwise -> DATA, with word index 0 and byte index 0.
- DATA, word assembly:
  - Bytes are little-endian: the byte at index k goes to bits [8k+7:8k].
  - Every accepted data byte is XORed into the checksum.
- DATA, word write:
  - On acceptance of byte index 3, the cycle after that posedge drives imem_we=1 for exactly one cycle, with imem_addr=word index and imem_wdata=the assembled word.
  - words_loaded increments on the same edge that raises imem_we.
  - The byte index wraps 3->0 and the word index increments.
- DATA, flow control:
  - Byte acceptance continues while imem_we is high; the write and the next byte overlap.
  - There is no stall and no bubble.
  - Gaps in in_valid simply hold all state.
- DATA -> CHECK on acceptance of the last byte of word N-1. The final word's write strobe occurs in the first CHECK cycle.
- CHECK:
  - The accepted byte is compared with the checksum accumulator.
  - Equal -> DONE; otherwise -> ERROR.
- DONE: done=1, cpu_reset=0. cpu_reset therefore falls on the cycle after the checksum handshake.
- ERROR: error=1, cpu_reset=1, in_ready=0. Held until start or reset.
- Partial loads:
  - On error or reset mid-load, previously written words remain in memory.
  - The CPU is never released with a partial image.
- imem_addr/imem_wdata hold their last values when imem_we=0.
- Width: N is compared as an 8-bit unsigned value against DEPTH.

Test Plan:
- Nominal load:
  - Stimulus: start; header 0x03; bytes b3 03 53 00, 33 85 84 40, 93 06 16 00; checksum 0x12.
  - Response: three single-cycle writes, addr0=0x005303b3, addr1=0x40848533, addr2=0x00160693; words_loaded=3.
  - Response: done=1 and cpu_reset=0 the cycle after the checksum handshake; error=0.
- Bad checksum:
  - Stimulus: same image with checksum 0x13.
  - Response: all three writes occur; then error=1, done=0, cpu_reset stays 1, in_ready=0.
- Bad header:
  - Stimulus: header 0x00, then separately header 0x21 (33).
  - Response: ERROR the cycle after the header handshake; no imem_we pulse.
  - Response: a following start plus the nominal image reaches DONE.
- Backpressure and gaps:
  - Stimulus: nominal image with in_valid low for 1–3 random cycles between bytes.
  - Response: identical writes and checksum result; imem_we is never asserted twice for one word.
  - Stimulus: back-to-back bytes.
  - Response: imem_we pulses spaced exactly 4 cycles apart.
- Reset mid-load:
  - Stimulus: assert reset after 6 data bytes.
  - Response: next cycle state=IDLE, in_ready=0, cpu_reset=1, words_loaded=0; the word at addr0 remains 0x005303b3.
  - Stimulus: reload with header 0x01, word 0xdeadbeef, checksum 0x22 (ef^be^ad^de).
  - Response: DONE.
- Start ignored while busy:
  - Stimulus: pulse start during DATA and again during CHECK.
  - Response: no restart; load completes normally.
  - Stimulus: start in DONE.
  - Response: cpu_reset=1 and done=0 the next cycle (HEADER).
